fetch_memory_responder: RTL and testbench
=========================================

# fetch_memory_responder

Instruction-memory responder for the fetch stage's memory-bus reads. It accepts one 8-byte-aligned read request at a time and holds it for a configurable access latency. It then presents a `bus_read_response` whose 64-bit payload packs two consecutive `instruction_t` words (slot 0 at the lower address), as the fetcher's local two-instruction cache expects. It sits between the fetch stage's memory-bus port and a word-addressed instruction store.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 64-bit words in the store.
- `READ_LATENCY`, 2: cycles from request acceptance to response valid; legal range 1..15.
- `INIT_FILE`, "": hex image loaded with `$readmemh` at elaboration; empty means all zeros.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  read request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a `clk` edge.
- `req_address`  in  64  `memory_address_t` byte address.
- `req_bus_id`  in  8  requester id (fetch passes `memory_bus_id`).
- `resp_valid`  out  1  response available (the fetcher's `response_busy`).
- `resp_ack`  in  1  response consumed (`get_response`); only meaningful while `resp_valid` is high.
- `resp_packet_type`  out  `bus_packet_type_t`  always `bus_read_response` while valid.
- `resp_address`  out  64  aligned address served.
- `resp_bus_id`  out  8  echo of `req_bus_id`.
- `resp_payload`  out  64  `fetched_instruction_data_t`-compatible word.
- `err_misaligned`  out  1  sticky; set when an accepted address has bits [2:0] nonzero.
- `err_range`  out  1  sticky; set when an accepted word index is ≥ `DEPTH_WORDS`.

## Operation
The block is a three-state FSM: IDLE, ACCESS, RESPOND.
- **IDLE:** `req_ready` = 1. On accept:
  - latch the aligned address `req_address & ~64'h7` and `req_bus_id`;
  - load the latency counter with `READ_LATENCY-1`;
  - move to ACCESS.
- **ACCESS:**
  - Each cycle with counter ≠ 0, decrement the counter.
  - With counter = 0, read the store at word index `addr[63:3]` into `resp_payload` and move to RESPOND.
- **RESPOND:** `resp_valid` = 1 and all `resp_*` outputs stay stable until `resp_ack`.
  - `resp_ack` without `req_valid`: go to IDLE.
  - `resp_ack && req_valid`: back-to-back case. Accept the new request in the same cycle (`req_ready` = `resp_ack` here) and go straight to ACCESS.
- **Misaligned address:** low bits are dropped, the aligned word is served, and `err_misaligned` is set.
- **Out-of-range index:** payload is 64'h0 and `err_range` is set. The response is still produced, so the fetcher never hangs.
- **Ack outside RESPOND:** `resp_ack` while `resp_valid` = 0 is ignored.
- **Request and response ordering:** strictly one outstanding request; responses return in request order.

## Timing
- **Reset values:** on reset the FSM goes to IDLE and all outputs clear:
  - `req_ready` = 0 during the reset cycle, then 1;
  - `resp_valid`, `resp_payload`, `resp_address`, `resp_bus_id` = 0;
  - both error flags = 0.
- **Reset mid-operation:** a pending request is dropped and no response is issued.
- **Latency:** a request accepted at edge N gives `resp_valid` = 1 after edge N+`READ_LATENCY`.
  - Sustained throughput is one response per `READ_LATENCY` cycles with ack in the same cycle as valid.
- **Response hold:** with ack held low, the response is held indefinitely.
- **Store timing:** the store is read synchronously in the final ACCESS cycle. There is no write port, so there is no read/write hazard.

## Configuration
- `FETCH_RESPONDER_STATS_EN` defined: adds three 32-bit outputs, all reset to 0, each saturating at 32'hFFFFFFFF:
  - `stat_reads`: increments on every accepted request;
  - `stat_stall_cycles`: increments each cycle in RESPOND with `resp_ack` = 0;
  - `stat_errors`: increments on every accepted misaligned or out-of-range request.
- Undefined: these ports and counters do not exist.

## Structure
- **Shared bus package:**
  - `bus_packet_type_t`, including `bus_read_response`;
  - `memory_address_t`;
  - the 8-bit bus-id type;
  - `INSN_BYTES` = `$bits(instruction_t)/8`.
- **Local to the block:** the FSM state enum.
- **Sub-module:** one, `insn_word_store`. It is a synchronous-read ROM of `DEPTH_WORDS`×64 with `INIT_FILE` load and an out-of-range zero return.

## Test plan
- **Single aligned read:** image word 3 = 64'h0000000200000011. Request address 0x18, `READ_LATENCY` = 2.
  - Expect `resp_valid` after 2 edges with payload 64'h0000000200000011, `resp_address` 0x18, type `bus_read_response`.
- **Misaligned read:** request address 0x1C.
  - Expect the word-3 payload, `resp_address` 0x18, `err_misaligned` = 1 and staying 1 after the next aligned request.
- **Back-to-back:** ack in the same cycle as valid while a new request to 0x20 is presented.
  - Expect the new request accepted that cycle and the second `resp_valid` exactly 2 edges later.
- **Held response:** withhold ack for 5 cycles.
  - Expect outputs stable, `req_ready` = 0, and `stat_reads` = 1, `stat_stall_cycles` = 5 when `FETCH_RESPONDER_STATS_EN` is defined.
- **Out-of-range read:** request index `DEPTH_WORDS`.
  - Expect payload 0 and `err_range` = 1.
- **Reset mid-operation:** assert reset in ACCESS.
  - Expect no `resp_valid` afterwards, `req_ready` = 1 the cycle after reset deasserts, and flags cleared.

Source files
------------

// File: rtl/fetch_memory_responder_pkg.sv
// rtl/fetch_memory_responder_pkg.sv - shared bus types for the fetch memory responder
// Packet, address and bus-id types plus the instruction geometry used to align reads.
package fetch_memory_responder_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [63:0] memory_address_t;
  typedef logic [7:0]  bus_id_t;
  typedef logic [63:0] fetched_instruction_data_t;

  typedef enum logic [1:0] {
    bus_idle,
    bus_read_request,
    bus_read_response,
    bus_write_request
  } bus_packet_type_t;

  localparam int INSN_BYTES = $bits(instruction_t) / 8;
  localparam int WORD_BYTES = 2 * INSN_BYTES;

  // A response word carries two instructions, so requests snap down to a word boundary.
  function automatic memory_address_t align_address(input memory_address_t addr);
    return addr & ~memory_address_t'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_memory_responder_insn_word_store.sv
// rtl/fetch_memory_responder_insn_word_store.sv - synchronous-read instruction ROM
// DEPTH_WORDS x 64 store; out-of-range reads return zero.
module insn_word_store
  import fetch_memory_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic [60:0]               rd_index,
  output fetched_instruction_data_t rd_data
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [63:0] mem [DEPTH_WORDS];

  fetched_instruction_data_t data_d, data_q;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;

  assign in_range = rd_index < 61'(DEPTH_WORDS);
  assign idx      = rd_index[IDX_W-1:0];

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = in_range ? mem[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign rd_data = data_q;

endmodule

// File: rtl/fetch_memory_responder.sv
// rtl/fetch_memory_responder.sv - fetch-stage instruction memory responder (IDLE/ACCESS/RESPOND)
// Optional FETCH_RESPONDER_STATS_EN adds saturating read/stall/error counters.
module fetch_memory_responder
  import fetch_memory_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS  = 1024,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  memory_address_t           req_address,
  input  bus_id_t                   req_bus_id,
  output logic                      resp_valid,
  input  logic                      resp_ack,
  output bus_packet_type_t          resp_packet_type,
  output memory_address_t           resp_address,
  output bus_id_t                   resp_bus_id,
  output fetched_instruction_data_t resp_payload,
  output logic                      err_misaligned,
`ifdef FETCH_RESPONDER_STATS_EN
  output logic [31:0]               stat_reads,
  output logic [31:0]               stat_stall_cycles,
  output logic [31:0]               stat_errors,
`endif
  output logic                      err_range
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESPOND} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  state_t          state_d, state_q;
  logic [3:0]      cnt_d, cnt_q;
  memory_address_t addr_d, addr_q;
  bus_id_t         bus_id_d, bus_id_q;
  logic            err_mis_d, err_mis_q;
  logic            err_rng_d, err_rng_q;

  logic accept;
  logic req_misaligned;
  logic req_out_of_range;
  logic rd_en;

  // Back-to-back: the ack that frees RESPOND also opens the request port that cycle.
  assign req_ready = !reset && ((state_q == ST_IDLE) ||
                                ((state_q == ST_RESPOND) && resp_ack));
  assign accept           = req_valid && req_ready;
  assign req_misaligned   = |req_address[2:0];
  assign req_out_of_range = req_address[63:3] >= 61'(DEPTH_WORDS);
  assign rd_en            = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    bus_id_d  = bus_id_q;
    err_mis_d = err_mis_q;
    err_rng_d = err_rng_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) state_d = ST_RESPOND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESPOND: begin
        if (resp_ack) state_d = accept ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      addr_d    = align_address(req_address);
      bus_id_d  = req_bus_id;
      cnt_d     = LAT_LOAD;
      err_mis_d = err_mis_q | req_misaligned;
      err_rng_d = err_rng_q | req_out_of_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      bus_id_q  <= '0;
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      bus_id_q  <= bus_id_d;
      err_mis_q <= err_mis_d;
      err_rng_q <= err_rng_d;
    end
  end

  insn_word_store #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_index (addr_q[63:3]),
    .rd_data  (resp_payload)
  );

  assign resp_valid       = (state_q == ST_RESPOND);
  assign resp_packet_type = resp_valid ? bus_read_response : bus_idle;
  assign resp_address     = addr_q;
  assign resp_bus_id      = bus_id_q;
  assign err_misaligned   = err_mis_q;
  assign err_range        = err_rng_q;

`ifdef FETCH_RESPONDER_STATS_EN
  logic [31:0] reads_d, reads_q;
  logic [31:0] stalls_d, stalls_q;
  logic [31:0] errors_d, errors_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    reads_d  = reads_q;
    stalls_d = stalls_q;
    errors_d = errors_q;
    if (accept) reads_d = sat_inc(reads_q);
    if (accept && (req_misaligned || req_out_of_range)) errors_d = sat_inc(errors_q);
    if ((state_q == ST_RESPOND) && !resp_ack) stalls_d = sat_inc(stalls_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reads_q  <= '0;
      stalls_q <= '0;
      errors_q <= '0;
    end else begin
      reads_q  <= reads_d;
      stalls_q <= stalls_d;
      errors_q <= errors_d;
    end
  end

  assign stat_reads        = reads_q;
  assign stat_stall_cycles = stalls_q;
  assign stat_errors       = errors_q;
`endif

endmodule

// File: tb/tb_fetch_memory_responder.sv
// tb/tb_fetch_memory_responder.sv - directed scoreboard bench for fetch_memory_responder
// Optional FETCH_RESPONDER_STATS_EN enables the counter checks.
module tb_fetch_memory_responder;
  import fetch_memory_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  memory_address_t           req_address;
  bus_id_t                   req_bus_id;
  logic                      resp_valid;
  logic                      resp_ack;
  bus_packet_type_t          resp_packet_type;
  memory_address_t           resp_address;
  bus_id_t                   resp_bus_id;
  fetched_instruction_data_t resp_payload;
  logic                      err_misaligned;
  logic                      err_range;
`ifdef FETCH_RESPONDER_STATS_EN
  logic [31:0] stat_reads, stat_stall_cycles, stat_errors;
`endif

  always #5 clk = ~clk;

  fetch_memory_responder #(
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT),
    .INIT_FILE    ("")
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_address      (req_address),
    .req_bus_id       (req_bus_id),
    .resp_valid       (resp_valid),
    .resp_ack         (resp_ack),
    .resp_packet_type (resp_packet_type),
    .resp_address     (resp_address),
    .resp_bus_id      (resp_bus_id),
    .resp_payload     (resp_payload),
    .err_misaligned   (err_misaligned),
`ifdef FETCH_RESPONDER_STATS_EN
    .stat_reads        (stat_reads),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_errors       (stat_errors),
`endif
    .err_range        (err_range)
  );

  typedef struct {
    logic [63:0] payload;
    logic [63:0] addr;
    logic [7:0]  id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] W3 = 64'h0000_0002_0000_0011;
  localparam logic [63:0] W4 = 64'h0000_0004_0000_0033;
  localparam logic [63:0] W5 = 64'hDEAD_BEEF_CAFE_F00D;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] payload, input logic [63:0] addr, input logic [7:0] id);
    exp_t e;
    e.payload = payload;
    e.addr    = addr;
    e.id      = id;
    sb.push_back(e);
  endtask

  // Called at a negedge with inputs already driven; consumes the accepting edge.
  task automatic issue(input logic [63:0] addr, input logic [7:0] id, input string tag);
    req_valid   = 1'b1;
    req_address = addr;
    req_bus_id  = id;
    #1;
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    resp_ack  = 1'b0;
  endtask

  // Counts edges after the accepting edge until resp_valid, then checks against the scoreboard.
  task automatic wait_resp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_payload"}, resp_payload, e.payload);
      check({tag, "_address"}, resp_address, e.addr);
      check({tag, "_bus_id"}, 64'(resp_bus_id), 64'(e.id));
      check({tag, "_type"}, 64'(resp_packet_type), 64'(bus_read_response));
    end
  endtask

  task automatic ack_idle();
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] held_payload;
    int          valid_seen;

    dut.u_store.mem[3] = W3;
    dut.u_store.mem[4] = W4;
    dut.u_store.mem[5] = W5;

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_address = '0;
    req_bus_id  = '0;
    resp_ack    = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_payload", resp_payload, 64'd0);
    check("rst_address", resp_address, 64'd0);
    check("rst_bus_id", 64'(resp_bus_id), 64'd0);
    check("rst_errs", {62'd0, err_misaligned, err_range}, 64'd0);

    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Single aligned read, then hold the response for five cycles.
    push_exp(W3, 64'h18, 8'h11);
    issue(64'h18, 8'h11, "aligned");
    wait_resp("aligned");
    held_payload = resp_payload;
    repeat (5) @(negedge clk);
    check("held_valid", 64'(resp_valid), 64'd1);
    check("held_payload", resp_payload, held_payload);
    check("held_address", resp_address, 64'h18);
    check("held_req_ready", 64'(req_ready), 64'd0);
`ifdef FETCH_RESPONDER_STATS_EN
    check("stat_reads", 64'(stat_reads), 64'd1);
    check("stat_stalls", 64'(stat_stall_cycles), 64'd5);
`endif
    ack_idle();
    check("after_ack_valid", 64'(resp_valid), 64'd0);

    // Ack with nothing pending is ignored.
    ack_idle();
    check("stray_ack_valid", 64'(resp_valid), 64'd0);
    check("stray_ack_ready", 64'(req_ready), 64'd1);

    // Misaligned read serves the containing word.
    push_exp(W3, 64'h18, 8'h22);
    issue(64'h1C, 8'h22, "misaligned");
    wait_resp("misaligned");
    check("err_misaligned_set", 64'(err_misaligned), 64'd1);
    check("err_range_clear", 64'(err_range), 64'd0);

    // Back-to-back: ack and new request in the same cycle.
    resp_ack = 1'b1;
    push_exp(W4, 64'h20, 8'h33);
    issue(64'h20, 8'h33, "b2b");
    wait_resp("b2b");
    check("err_misaligned_sticky", 64'(err_misaligned), 64'd1);
    resp_ack = 1'b1;
    push_exp(W5, 64'h28, 8'h44);
    issue(64'h28, 8'h44, "b2b2");
    wait_resp("b2b2");
    ack_idle();

    // Out-of-range word index.
    push_exp(64'd0, 64'(DEPTH) * 64'd8, 8'h55);
    issue(64'(DEPTH) * 64'd8, 8'h55, "range");
    wait_resp("range");
    check("err_range_set", 64'(err_range), 64'd1);
`ifdef FETCH_RESPONDER_STATS_EN
    check("stat_errors", 64'(stat_errors), 64'd2);
    check("stat_reads_total", 64'(stat_reads), 64'd5);
`endif
    ack_idle();

    // Reset while in ACCESS drops the request.
    issue(64'h18, 8'h66, "midrst");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_errs", {62'd0, err_misaligned, err_range}, 64'd0);
    valid_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) valid_seen++;
    end
    check("midrst_no_resp", 64'(valid_seen), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
